// File: rtl/alu_pkg.sv
// Shared constants for the ALU sharing controller: default widths, latency,
// requester-id width and FSM state encodings.
package alu_pkg;

  localparam int unsigned DEF_WIDTH   = 8;
  localparam int unsigned DEF_FN_W    = 2;
  localparam int unsigned DEF_ALU_LAT = 1;
  localparam int unsigned ID_W        = 1;

  localparam int unsigned ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_EXEC = 2'd1;
  localparam logic [ST_W-1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant: a lone requester wins; on contention prio wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) gnt = prio ? 2'b10 : 2'b01;
    else              gnt = req;
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one registered ALU between two requesters: round-robin accept,
// wait ALU_LAT cycles, capture result/zero and hand it back to the owner.
module alu_share_ctrl #(
  parameter int unsigned WIDTH   = alu_pkg::DEF_WIDTH,
  parameter int unsigned FN_W    = alu_pkg::DEF_FN_W,
  parameter int unsigned ALU_LAT = alu_pkg::DEF_ALU_LAT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                req_valid,
  output logic [1:0]                req_ready,
  input  logic [WIDTH-1:0]          req0_op1,
  input  logic [WIDTH-1:0]          req0_op2,
  input  logic [FN_W-1:0]           req0_fn,
  input  logic [WIDTH-1:0]          req1_op1,
  input  logic [WIDTH-1:0]          req1_op2,
  input  logic [FN_W-1:0]           req1_fn,
  output logic [1:0]                rsp_valid,
  input  logic [1:0]                rsp_ready,
  output logic [WIDTH-1:0]          rsp_result,
  output logic                      rsp_zero,
  output logic [WIDTH-1:0]          alu_op1,
  output logic [WIDTH-1:0]          alu_op2,
  output logic [FN_W-1:0]           alu_fn,
  input  logic [WIDTH-1:0]          alu_result,
  input  logic                      alu_zero,
  output logic                      busy,
  output logic [alu_pkg::ID_W-1:0]  grant_id
);

  import alu_pkg::*;

  localparam int unsigned CNT_W = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

  logic [ST_W-1:0]  state, state_nxt;
  logic             prio, prio_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] alu_op1_nxt, alu_op2_nxt, rsp_result_nxt;
  logic [FN_W-1:0]  alu_fn_nxt;
  logic             rsp_zero_nxt, busy_nxt;
  logic [ID_W-1:0]  grant_id_nxt;
  logic [1:0]       rsp_valid_nxt;
  logic [1:0]       gnt;

  rr_arb2 u_arb (
    .req  (req_valid),
    .prio (prio),
    .gnt  (gnt)
  );

  // Ready is only offered in IDLE, and never while reset is asserted.
  assign req_ready = (rst_n && (state == ST_IDLE)) ? gnt : 2'b00;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      prio       <= 1'b0;
      cnt        <= '0;
      alu_op1    <= '0;
      alu_op2    <= '0;
      alu_fn     <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      grant_id   <= '0;
      rsp_valid  <= 2'b00;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      prio       <= prio_nxt;
      cnt        <= cnt_nxt;
      alu_op1    <= alu_op1_nxt;
      alu_op2    <= alu_op2_nxt;
      alu_fn     <= alu_fn_nxt;
      rsp_result <= rsp_result_nxt;
      rsp_zero   <= rsp_zero_nxt;
      grant_id   <= grant_id_nxt;
      rsp_valid  <= rsp_valid_nxt;
      busy       <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    prio_nxt       = prio;
    cnt_nxt        = cnt;
    alu_op1_nxt    = alu_op1;
    alu_op2_nxt    = alu_op2;
    alu_fn_nxt     = alu_fn;
    rsp_result_nxt = rsp_result;
    rsp_zero_nxt   = rsp_zero;
    grant_id_nxt   = grant_id;
    rsp_valid_nxt  = rsp_valid;

    case (state)
      ST_IDLE: begin
        if (gnt != 2'b00) begin
          alu_op1_nxt  = gnt[1] ? req1_op1 : req0_op1;
          alu_op2_nxt  = gnt[1] ? req1_op2 : req0_op2;
          alu_fn_nxt   = gnt[1] ? req1_fn  : req0_fn;
          grant_id_nxt = ID_W'(gnt[1]);
          prio_nxt     = ~gnt[1];
          cnt_nxt      = CNT_W'(ALU_LAT);
          state_nxt    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt == '0) begin
          rsp_result_nxt = alu_result;
          rsp_zero_nxt   = alu_zero;
          rsp_valid_nxt  = {grant_id[0], ~grant_id[0]};
          state_nxt      = ST_RESP;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready[grant_id]) begin
          rsp_valid_nxt = 2'b00;
          state_nxt     = ST_IDLE;
        end
      end
      default: begin
        rsp_valid_nxt = 2'b00;
        state_nxt     = ST_IDLE;
      end
    endcase

    busy_nxt = (state_nxt != ST_IDLE);
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl: main instance with a registered ALU stub
// (ALU_LAT=1) plus ALU_LAT=0 and ALU_LAT=3 instances for the latency sweep.
module tb_alu_share_ctrl;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [1:0] fn, input logic [7:0] a, input logic [7:0] b);
    case (fn)
      2'd1:    return a + b;
      2'd2:    return a - b;
      2'd3:    return a & b;
      default: return a;
    endcase
  endfunction

  // main instance, ALU_LAT = 1
  logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [7:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic [1:0] req0_fn, req1_fn;
  logic [7:0] rsp_result, alu_op1, alu_op2, alu_result;
  logic       rsp_zero, alu_zero, busy;
  logic [1:0] alu_fn;
  logic [0:0] grant_id;

  alu_share_ctrl #(.WIDTH(8), .FN_W(2), .ALU_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_fn(req0_fn),
    .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_fn(req1_fn),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_fn(alu_fn),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .busy(busy), .grant_id(grant_id)
  );

  always_ff @(posedge clk) alu_result <= alu_f(alu_fn, alu_op1, alu_op2);
  assign alu_zero = (alu_result == 8'd0);

  // sweep instances share request inputs
  logic [1:0] sw_valid;
  logic [7:0] sw_op1, sw_op2;
  logic [1:0] sw_fn;

  logic [1:0] z_rr, z_rv, z_fn;
  logic [7:0] z_res, z_op1, z_op2, z_alu_res;
  logic       z_zero, z_alu_zero, z_busy;
  logic [0:0] z_gid;

  alu_share_ctrl #(.WIDTH(8), .FN_W(2), .ALU_LAT(0)) dut_lat0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(sw_valid), .req_ready(z_rr),
    .req0_op1(sw_op1), .req0_op2(sw_op2), .req0_fn(sw_fn),
    .req1_op1(sw_op1), .req1_op2(sw_op2), .req1_fn(sw_fn),
    .rsp_valid(z_rv), .rsp_ready(2'b11),
    .rsp_result(z_res), .rsp_zero(z_zero),
    .alu_op1(z_op1), .alu_op2(z_op2), .alu_fn(z_fn),
    .alu_result(z_alu_res), .alu_zero(z_alu_zero),
    .busy(z_busy), .grant_id(z_gid)
  );

  assign z_alu_res  = alu_f(z_fn, z_op1, z_op2);
  assign z_alu_zero = (z_alu_res == 8'd0);

  logic [1:0] t_rr, t_rv, t_fn;
  logic [7:0] t_res, t_op1, t_op2, t_s1, t_s2, t_s3;
  logic       t_zero, t_alu_zero, t_busy;
  logic [0:0] t_gid;

  alu_share_ctrl #(.WIDTH(8), .FN_W(2), .ALU_LAT(3)) dut_lat3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(sw_valid), .req_ready(t_rr),
    .req0_op1(sw_op1), .req0_op2(sw_op2), .req0_fn(sw_fn),
    .req1_op1(sw_op1), .req1_op2(sw_op2), .req1_fn(sw_fn),
    .rsp_valid(t_rv), .rsp_ready(2'b11),
    .rsp_result(t_res), .rsp_zero(t_zero),
    .alu_op1(t_op1), .alu_op2(t_op2), .alu_fn(t_fn),
    .alu_result(t_s3), .alu_zero(t_alu_zero),
    .busy(t_busy), .grant_id(t_gid)
  );

  always_ff @(posedge clk) begin
    t_s1 <= alu_f(t_fn, t_op1, t_op2);
    t_s2 <= t_s1;
    t_s3 <= t_s2;
  end
  assign t_alu_zero = (t_s3 == 8'd0);

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept from IDLE, wait for the response, check it, then complete the handshake.
  task automatic serve(input string tag, input logic [1:0] exp_rr, input logic [1:0] exp_vld,
                       input logic [7:0] exp_res, input logic exp_zero, input logic exp_gid);
    int lat;
    check({tag, "_req_ready"}, 32'(req_ready), 32'(exp_rr));
    step();
    check({tag, "_busy_exec"}, 32'(busy), 32'd1);
    lat = 0;
    while (rsp_valid == 2'b00 && lat < 12) begin
      step();
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'd2);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(exp_vld));
    check({tag, "_result"}, 32'(rsp_result), 32'(exp_res));
    check({tag, "_zero"}, 32'(rsp_zero), 32'(exp_zero));
    check({tag, "_grant_id"}, 32'(grant_id), 32'(exp_gid));
    step();
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int lz, lt, seen;
    logic [7:0] rz, rt;

    rst_n = 1'b0;
    req_valid = 2'b11; rsp_ready = 2'b00;
    req0_op1 = 8'd0; req0_op2 = 8'd0; req0_fn = 2'd0;
    req1_op1 = 8'd0; req1_op2 = 8'd0; req1_fn = 2'd0;
    sw_valid = 2'b00; sw_op1 = 8'd2; sw_op2 = 8'd4; sw_fn = 2'd1;

    // reset
    step(); step();
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_alu_op1", 32'(alu_op1), 32'd0);
    check("rst_alu_op2", 32'(alu_op2), 32'd0);
    check("rst_alu_fn", 32'(alu_fn), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_req_ready", 32'(req_ready), 32'b01);
    req_valid = 2'b00;
    step();

    // single op on requester 0: 2+4=6
    req0_op1 = 8'd2; req0_op2 = 8'd4; req0_fn = 2'd1;
    req_valid = 2'b01; rsp_ready = 2'b11;
    #1;
    serve("single", 2'b01, 2'b01, 8'd6, 1'b0, 1'b0);
    req_valid = 2'b00;
    step();

    // backpressure on requester 1: 7-7=0, zero=1; prio is now 1
    req1_op1 = 8'd7; req1_op2 = 8'd7; req1_fn = 2'd2;
    req_valid = 2'b10; rsp_ready = 2'b01;
    #1;
    check("bp_req_ready", 32'(req_ready), 32'b10);
    step();
    req_valid = 2'b01;
    lz = 0;
    while (rsp_valid == 2'b00 && lz < 12) begin
      step();
      lz++;
    end
    check("bp_lat", 32'(lz), 32'd2);
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", 32'(rsp_valid), 32'b10);
      check("bp_result", 32'(rsp_result), 32'd0);
      check("bp_zero", 32'(rsp_zero), 32'd1);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      step();
    end
    rsp_ready = 2'b11;
    step();
    check("bp_busy_after", 32'(busy), 32'd0);
    check("bp_rsp_drop", 32'(rsp_valid), 32'd0);

    // contention: req0 5-3=2, req1 1&3=1, alternating
    req0_op1 = 8'd5; req0_op2 = 8'd3; req0_fn = 2'd2;
    req1_op1 = 8'd1; req1_op2 = 8'd3; req1_fn = 2'd3;
    req_valid = 2'b11;
    #1;
    serve("cont0", 2'b01, 2'b01, 8'd2, 1'b0, 1'b0);
    serve("cont1", 2'b10, 2'b10, 8'd1, 1'b0, 1'b1);
    serve("cont2", 2'b01, 2'b01, 8'd2, 1'b0, 1'b0);
    req_valid = 2'b00;
    step();

    // reset during EXEC of req0 {9,1,add}
    req0_op1 = 8'd9; req0_op2 = 8'd1; req0_fn = 2'd1;
    req_valid = 2'b01;
    #1;
    step();
    req_valid = 2'b00;
    check("midrst_busy_exec", 32'(busy), 32'd1);
    rst_n = 1'b0;
    step(); step();
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_alu_op1", 32'(alu_op1), 32'd0);
    rst_n = 1'b1;
    req_valid = 2'b11;
    #1;
    check("midrst_prio0", 32'(req_ready), 32'b01);
    req_valid = 2'b00;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (rsp_valid != 2'b00 || busy) seen = 1;
    end
    check("midrst_no_rsp", 32'(seen), 32'd0);

    // latency sweep: ALU_LAT=0 -> 1 cycle, ALU_LAT=3 -> 4 cycles
    sw_valid = 2'b01;
    #1;
    step();
    sw_valid = 2'b00;
    lz = -1; lt = -1; rz = 8'd0; rt = 8'd0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (lz < 0 && z_rv != 2'b00) begin lz = i; rz = z_res; end
      if (lt < 0 && t_rv != 2'b00) begin lt = i; rt = t_res; end
    end
    check("lat0_cycles", 32'(lz), 32'd1);
    check("lat0_result", 32'(rz), 32'd6);
    check("lat3_cycles", 32'(lt), 32'd4);
    check("lat3_result", 32'(rt), 32'd6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
